// File: rtl/board_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// board_ram_arbiter_if
//
// Bundles every requester and RAM-port signal of board_ram_arbiter so the
// arbiter and its neighbours connect through a single port.
//
//   edit requester    : e_req, e_we, e_lock, e_addr, e_wdata -> e_gnt, e_rvalid
//   step requester    : s_req, s_we, s_addr, s_wdata         -> s_gnt, s_rvalid
//   display requester : d_req, d_addr                        -> d_gnt, d_rvalid
//   shared read data  : rdata
//   RAM port          : ram_addr, ram_wdata, ram_wren        <- ram_q
//   status pulses     : addr_err, lock_timeout
//
// Modports:
//   master - the requesters and the RAM (drive requests and ram_q)
//   slave  - the arbiter (drives grants, read returns and the RAM port)
// -----------------------------------------------------------------------------
interface board_ram_arbiter_if #(
  parameter int ROW_W  = 40,
  parameter int ADDR_W = 5
);
  // edit path
  logic              e_req;
  logic              e_we;
  logic              e_lock;
  logic [ADDR_W-1:0] e_addr;
  logic [ROW_W-1:0]  e_wdata;
  logic              e_gnt;
  logic              e_rvalid;

  // generation-step engine
  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [ROW_W-1:0]  s_wdata;
  logic              s_gnt;
  logic              s_rvalid;

  // display scan-out
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;

  // shared read data
  logic [ROW_W-1:0]  rdata;

  // RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [ROW_W-1:0]  ram_wdata;
  logic              ram_wren;
  logic [ROW_W-1:0]  ram_q;

  // status
  logic              addr_err;
  logic              lock_timeout;

  modport master (
    output e_req, e_we, e_lock, e_addr, e_wdata,
    output s_req, s_we, s_addr, s_wdata,
    output d_req, d_addr,
    output ram_q,
    input  e_gnt, e_rvalid, s_gnt, s_rvalid, d_gnt, d_rvalid,
    input  rdata, ram_addr, ram_wdata, ram_wren, addr_err, lock_timeout
  );

  modport slave (
    input  e_req, e_we, e_lock, e_addr, e_wdata,
    input  s_req, s_we, s_addr, s_wdata,
    input  d_req, d_addr,
    input  ram_q,
    output e_gnt, e_rvalid, s_gnt, s_rvalid, d_gnt, d_rvalid,
    output rdata, ram_addr, ram_wdata, ram_wren, addr_err, lock_timeout
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// -----------------------------------------------------------------------------
// board_ram_arbiter
//
// Shares the single-port board RAM between the edit path, the generation-step
// engine and the display scan-out. At most one requester is granted per cycle;
// the granted requester drives the RAM port combinationally, and read data
// comes back one cycle later with the issuing requester's rvalid.
//
// Ports:
//   clk     - clock
//   reset_n - synchronous active-low reset
//   bus     - board_ram_arbiter_if.slave (requests, grants, read returns,
//             RAM port, addr_err / lock_timeout pulses)
//
// Arbitration:
//   ARB    : edit first, then step/display by a round-robin pointer.
//   LOCKED : only edit may be granted; entered when edit is granted with
//            e_lock high, left when e_lock drops or the lock runs too long.
//   After a forced release the edit path is kept out of arbitration while it
//   still asserts e_lock, so step/display get the port; once e_lock has been
//   seen low, edit competes normally again.
// -----------------------------------------------------------------------------
module board_ram_arbiter #(
  parameter int ROW_W    = 40,
  parameter int ADDR_W   = 5,
  parameter int ROWS     = 30,
  parameter int LOCK_MAX = 4
) (
  input logic               clk,
  input logic               reset_n,
  board_ram_arbiter_if.slave bus
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [ADDR_W:0]  ROWS_EXT  = (ADDR_W + 1)'(ROWS);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // registered state
  state_t           state;
  logic             rr;          // 0: step next on contention, 1: display
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_hold;   // forced release seen, waiting for e_lock low
  logic             e_rvalid_q;
  logic             s_rvalid_q;
  logic             d_rvalid_q;
  logic             addr_err_q;
  logic             rd_zero_q;   // pending read was out of range
  logic             lock_timeout_q;

  // next-state / combinational
  state_t           state_nx;
  logic             rr_nx;
  logic [CNT_W-1:0] lock_cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic             lock_hold_nx;
  logic             timeout_nx;
  logic             edit_ok;
  logic             gnt_e;
  logic             gnt_s;
  logic             gnt_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [ROW_W-1:0]  sel_wdata;
  logic              sel_we;
  logic              out_of_range;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_nx     = state;
    rr_nx        = rr;
    lock_cnt_nx  = lock_cnt;
    lock_hold_nx = lock_hold;
    timeout_nx   = 1'b0;
    gnt_e        = 1'b0;
    gnt_s        = 1'b0;
    gnt_d        = 1'b0;
    cnt_inc      = lock_cnt + CNT_W'(1);

    // Edit holding e_lock straight after a forced release is kept out.
    edit_ok = bus.e_req && !(lock_hold && bus.e_lock);

    if (!bus.e_lock) begin
      lock_hold_nx = 1'b0;
    end

    unique case (state)
      ARB: begin
        if (edit_ok) begin
          gnt_e = 1'b1;
          if (bus.e_lock) begin
            state_nx    = LOCKED;
            lock_cnt_nx = '0;
          end
        end else if (bus.s_req && bus.d_req) begin
          gnt_s = !rr;
          gnt_d = rr;
          rr_nx = !rr;
        end else if (bus.s_req) begin
          gnt_s = 1'b1;
          rr_nx = 1'b1;
        end else if (bus.d_req) begin
          gnt_d = 1'b1;
          rr_nx = 1'b0;
        end
      end

      LOCKED: begin
        gnt_e       = bus.e_req;
        lock_cnt_nx = cnt_inc;
        if (!bus.e_lock) begin
          state_nx    = ARB;
          lock_cnt_nx = '0;
        end else if (cnt_inc == LOCK_LAST) begin
          // Count reaching its limit ends the episode by force.
          state_nx     = ARB;
          lock_cnt_nx  = '0;
          timeout_nx   = 1'b1;
          lock_hold_nx = 1'b1;
        end
      end

      default: begin
        state_nx = ARB;
      end
    endcase
  end

  // RAM port follows the granted requester; display never writes.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (gnt_e) begin
      sel_addr  = bus.e_addr;
      sel_wdata = bus.e_wdata;
      sel_we    = bus.e_we;
    end else if (gnt_s) begin
      sel_addr  = bus.s_addr;
      sel_wdata = bus.s_wdata;
      sel_we    = bus.s_we;
    end else if (gnt_d) begin
      sel_addr  = bus.d_addr;
    end
    out_of_range = (gnt_e || gnt_s || gnt_d) && ({1'b0, sel_addr} >= ROWS_EXT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ARB;
      rr             <= 1'b0;
      lock_cnt       <= '0;
      lock_hold      <= 1'b0;
      e_rvalid_q     <= 1'b0;
      s_rvalid_q     <= 1'b0;
      d_rvalid_q     <= 1'b0;
      addr_err_q     <= 1'b0;
      rd_zero_q      <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state          <= state_nx;
      rr             <= rr_nx;
      lock_cnt       <= lock_cnt_nx;
      lock_hold      <= lock_hold_nx;
      e_rvalid_q     <= gnt_e && !bus.e_we;
      s_rvalid_q     <= gnt_s && !bus.s_we;
      d_rvalid_q     <= gnt_d;
      addr_err_q     <= out_of_range;
      rd_zero_q      <= out_of_range && !sel_we;
      lock_timeout_q <= timeout_nx;
    end
  end

  assign bus.e_gnt        = gnt_e;
  assign bus.s_gnt        = gnt_s;
  assign bus.d_gnt        = gnt_d;
  assign bus.ram_addr     = sel_addr;
  assign bus.ram_wdata    = sel_wdata;
  assign bus.ram_wren     = sel_we && !out_of_range;
  assign bus.e_rvalid     = e_rvalid_q;
  assign bus.s_rvalid     = s_rvalid_q;
  assign bus.d_rvalid     = d_rvalid_q;
  assign bus.rdata        = rd_zero_q ? '0 : bus.ram_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_board_ram_arbiter
//
// Drives board_ram_arbiter with a behavioural 32-word RAM (write-then-read,
// one-cycle read latency). A directed table covers reset, contention,
// read-modify-write, lock timeout, out-of-range and reset during a read; a
// random phase follows. A cycle-level reference model of the arbitration
// rules, with a shadow copy of the board contents, runs on every cycle.
// -----------------------------------------------------------------------------
module tb_board_ram_arbiter;

  localparam int ROW_W    = 40;
  localparam int ADDR_W   = 5;
  localparam int ROWS     = 30;
  localparam int LOCK_MAX = 4;

  logic clk;
  logic reset_n;

  board_ram_arbiter_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

  board_ram_arbiter #(
    .ROW_W(ROW_W), .ADDR_W(ADDR_W), .ROWS(ROWS), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // board RAM fixture
  logic [ROW_W-1:0] mem [32];
  always @(posedge clk) begin
    if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_q         <= bus.ram_wdata;
    end else begin
      bus.ram_q         <= mem[bus.ram_addr];
    end
  end

  function automatic logic [ROW_W-1:0] row_init(input int i);
    return {20'(i * 7 + 1), 20'hAB000 + 20'(i)};
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who may use the board this cycle, and what each
  // requester should see next cycle.
  // ---------------------------------------------------------------------------
  bit               m_locked;
  int               m_age;       // cycles in the current lock episode
  bit               m_hold;      // forced release, waiting for e_lock low
  int               m_turn;      // 0 step, 1 display
  logic [ROW_W-1:0] m_shadow [32];
  logic [2:0]       m_rv;        // {e,s,d}
  logic [ROW_W-1:0] m_rdata;
  logic             m_err;
  logic             m_to;

  task automatic model_reset();
    m_locked = 0; m_age = 0; m_hold = 0; m_turn = 0;
    m_rv = 3'b000; m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step();
    int               win;       // 0 none, 1 edit, 2 step, 3 display
    logic [2:0]       g;
    logic [ADDR_W-1:0] a;
    logic [ROW_W-1:0] wd;
    logic             we;
    logic             oor;
    logic             to;

    check("m.rvalid", {bus.e_rvalid, bus.s_rvalid, bus.d_rvalid}, m_rv);
    check("m.addr_err", bus.addr_err, m_err);
    check("m.lock_timeout", bus.lock_timeout, m_to);
    if (m_rv != 3'b000) check("m.rdata", bus.rdata, m_rdata);

    if (m_locked) win = bus.e_req ? 1 : 0;
    else if (bus.e_req && !(m_hold && bus.e_lock)) win = 1;
    else if (bus.s_req && bus.d_req) win = (m_turn == 0) ? 2 : 3;
    else if (bus.s_req) win = 2;
    else if (bus.d_req) win = 3;
    else win = 0;

    g = 3'b000; a = '0; wd = '0; we = 1'b0;
    case (win)
      1: begin g = 3'b100; a = bus.e_addr; wd = bus.e_wdata; we = bus.e_we; end
      2: begin g = 3'b010; a = bus.s_addr; wd = bus.s_wdata; we = bus.s_we; end
      3: begin g = 3'b001; a = bus.d_addr; end
      default: ;
    endcase
    oor = (win != 0) && (int'(a) >= ROWS);

    check("m.gnt", {bus.e_gnt, bus.s_gnt, bus.d_gnt}, g);
    check("m.ram_addr", bus.ram_addr, a);
    check("m.ram_wdata", bus.ram_wdata, wd);
    check("m.ram_wren", bus.ram_wren, we && !oor);

    if (we && !oor) m_shadow[a] = wd;

    if (!reset_n) begin
      model_reset();
    end else begin
      m_rv    = (win != 0 && !we) ? g : 3'b000;
      m_rdata = oor ? '0 : m_shadow[a];
      m_err   = oor;
      to      = 1'b0;
      if (m_locked) begin
        m_age++;
        if (!bus.e_lock) m_locked = 0;
        else if (m_age == LOCK_MAX) begin
          m_locked = 0; to = 1'b1; m_hold = 1;
        end
      end else if (win == 1 && bus.e_lock) begin
        m_locked = 1; m_age = 1;
      end
      if (!bus.e_lock) m_hold = 0;
      m_to = to;
      if (win == 2) m_turn = 1;
      if (win == 3) m_turn = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: one row per cycle. Expected registered outputs in a row
  // are the results of the previous row's cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    string             name;
    logic              rst_n;
    logic              e_req, e_we, e_lock;
    logic [ADDR_W-1:0] e_addr;
    logic [ROW_W-1:0]  e_wdata;
    logic              s_req, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [ROW_W-1:0]  s_wdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        x_gnt;     // {e,s,d}
    logic              x_wren;
    logic [2:0]        x_rvalid;  // {e,s,d}
    logic [ROW_W-1:0]  x_rdata;
    logic              x_err;
    logic              x_to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string n, input logic rs,
    input logic er, input logic ew, input logic el, input int ea, input logic [ROW_W-1:0] ewd,
    input logic sr, input logic sw, input int sa, input logic [ROW_W-1:0] swd,
    input logic dr, input int da,
    input logic [2:0] xg, input logic xw, input logic [2:0] xrv,
    input logic [ROW_W-1:0] xrd, input logic xe, input logic xt);
    vec_t v;
    v.name = n; v.rst_n = rs;
    v.e_req = er; v.e_we = ew; v.e_lock = el; v.e_addr = ADDR_W'(ea); v.e_wdata = ewd;
    v.s_req = sr; v.s_we = sw; v.s_addr = ADDR_W'(sa); v.s_wdata = swd;
    v.d_req = dr; v.d_addr = ADDR_W'(da);
    v.x_gnt = xg; v.x_wren = xw; v.x_rvalid = xrv; v.x_rdata = xrd;
    v.x_err = xe; v.x_to = xt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_n     = v.rst_n;
    bus.e_req   = v.e_req;   bus.e_we = v.e_we; bus.e_lock = v.e_lock;
    bus.e_addr  = v.e_addr;  bus.e_wdata = v.e_wdata;
    bus.s_req   = v.s_req;   bus.s_we = v.s_we;
    bus.s_addr  = v.s_addr;  bus.s_wdata = v.s_wdata;
    bus.d_req   = v.d_req;   bus.d_addr = v.d_addr;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(negedge clk);
    check({v.name, ".gnt"}, {bus.e_gnt, bus.s_gnt, bus.d_gnt}, v.x_gnt);
    check({v.name, ".ram_wren"}, bus.ram_wren, v.x_wren);
    check({v.name, ".rvalid"}, {bus.e_rvalid, bus.s_rvalid, bus.d_rvalid}, v.x_rvalid);
    check({v.name, ".addr_err"}, bus.addr_err, v.x_err);
    check({v.name, ".lock_timeout"}, bus.lock_timeout, v.x_to);
    if (v.x_rvalid != 3'b000) check({v.name, ".rdata"}, bus.rdata, v.x_rdata);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ROW_W-1:0] z;
    logic [ROW_W-1:0] ones;
    logic [ROW_W-1:0] rmw;
    vec_t v;
    z    = '0;
    ones = '1;
    rmw  = 40'h00000_F0000;

    for (int i = 0; i < 32; i++) begin
      mem[i]      = row_init(i);
      m_shadow[i] = row_init(i);
    end

    reset_n = 1'b0;
    v = mk("init", 0, 0,0,0,0,z, 0,0,0,z, 0,0, 3'b000,0,3'b000,z,0,0);
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    //          name       rs  er ew el ea ewd    sr sw sa swd    dr da  gnt    wr rvalid rdata          err to
    tbl.push_back(mk("idle",    1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b000, z,            0,0));
    tbl.push_back(mk("cont0",   1, 0,0,0,0, z,     1,0,3, z,     1,7, 3'b010,0, 3'b000, z,            0,0));
    tbl.push_back(mk("cont1",   1, 0,0,0,0, z,     1,0,3, z,     1,7, 3'b001,0, 3'b010, row_init(3),  0,0));
    tbl.push_back(mk("cont2",   1, 0,0,0,0, z,     1,0,3, z,     1,7, 3'b010,0, 3'b001, row_init(7),  0,0));
    tbl.push_back(mk("cont3",   1, 0,0,0,0, z,     1,0,3, z,     1,7, 3'b001,0, 3'b010, row_init(3),  0,0));
    tbl.push_back(mk("cont4",   1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b001, row_init(7),  0,0));
    tbl.push_back(mk("rmw_rd",  1, 1,0,1,5, z,     1,0,9, z,     0,0, 3'b100,0, 3'b000, z,            0,0));
    tbl.push_back(mk("rmw_wr",  1, 1,1,0,5, rmw,   1,0,9, z,     0,0, 3'b100,1, 3'b100, row_init(5),  0,0));
    tbl.push_back(mk("rmw_s",   1, 0,0,0,0, z,     1,0,9, z,     0,0, 3'b010,0, 3'b000, z,            0,0));
    tbl.push_back(mk("rmw_rb",  1, 0,0,0,0, z,     0,0,0, z,     1,5, 3'b001,0, 3'b010, row_init(9),  0,0));
    tbl.push_back(mk("rmw_chk", 1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b001, rmw,          0,0));
    tbl.push_back(mk("lk0",     1, 1,0,1,1, z,     1,0,2, z,     0,0, 3'b100,0, 3'b000, z,            0,0));
    tbl.push_back(mk("lk1",     1, 1,0,1,1, z,     1,0,2, z,     0,0, 3'b100,0, 3'b100, row_init(1),  0,0));
    tbl.push_back(mk("lk2",     1, 1,0,1,1, z,     1,0,2, z,     0,0, 3'b100,0, 3'b100, row_init(1),  0,0));
    tbl.push_back(mk("lk3",     1, 1,0,1,1, z,     1,0,2, z,     0,0, 3'b100,0, 3'b100, row_init(1),  0,0));
    tbl.push_back(mk("lk_to",   1, 0,0,1,1, z,     1,0,2, z,     0,0, 3'b010,0, 3'b100, row_init(1),  0,1));
    tbl.push_back(mk("lk_end",  1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b010, row_init(2),  0,0));
    tbl.push_back(mk("oor_wr",  1, 0,0,0,0, z,     1,1,30,ones,  0,0, 3'b010,0, 3'b000, z,            0,0));
    tbl.push_back(mk("oor_rd",  1, 0,0,0,0, z,     0,0,0, z,     1,31,3'b001,0, 3'b000, z,            1,0));
    tbl.push_back(mk("oor_ret", 1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b001, z,            1,0));
    tbl.push_back(mk("oor_end", 1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b000, z,            0,0));
    tbl.push_back(mk("rl_lock", 1, 1,0,1,2, z,     0,0,0, z,     0,0, 3'b100,0, 3'b000, z,            0,0));
    tbl.push_back(mk("rl_rst",  0, 0,0,1,2, z,     0,0,0, z,     1,4, 3'b000,0, 3'b100, row_init(2),  0,0));
    tbl.push_back(mk("rr_rst",  0, 0,0,0,0, z,     0,0,0, z,     1,4, 3'b001,0, 3'b000, z,            0,0));
    tbl.push_back(mk("rr_after",1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b000, z,            0,0));
    tbl.push_back(mk("arb_rd",  1, 0,0,0,0, z,     0,0,0, z,     1,6, 3'b001,0, 3'b000, z,            0,0));
    tbl.push_back(mk("arb_ret", 1, 0,0,0,0, z,     0,0,0, z,     0,0, 3'b000,0, 3'b001, row_init(6),  0,0));

    foreach (tbl[i]) apply(tbl[i]);

    // Randomized traffic checked by the reference model alone.
    for (int c = 0; c < 3000; c++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      bus.e_req     = ($urandom_range(0, 3) == 0);
      bus.e_we      = 1'($urandom_range(0, 1));
      bus.e_lock    = ($urandom_range(0, 2) != 0);
      bus.e_addr    = ADDR_W'($urandom_range(0, 31));
      bus.e_wdata   = {8'($urandom), 32'($urandom)};
      bus.s_req     = 1'($urandom_range(0, 1));
      bus.s_we      = 1'($urandom_range(0, 1));
      bus.s_addr    = ADDR_W'($urandom_range(0, 31));
      bus.s_wdata   = {8'($urandom), 32'($urandom)};
      bus.d_req     = 1'($urandom_range(0, 1));
      bus.d_addr    = ADDR_W'($urandom_range(0, 31));
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
